// File: rtl/activation_cache_if.sv
// Handshake and tap bundle for activation_cache: one sample in, four dilated taps out.
interface activation_cache_if #(
  parameter int W = 16,
  parameter int D = 8
);
  logic           inp_v;
  logic [D*W-1:0] packed_in;
  logic           ready;
  logic [D*W-1:0] packed_a0;
  logic [D*W-1:0] packed_a1;
  logic [D*W-1:0] packed_a2;
  logic [D*W-1:0] packed_a3;
  logic           out_v;
  logic           primed;
  logic           overrun;

  modport master (
    output inp_v, packed_in,
    input  ready, packed_a0, packed_a1, packed_a2, packed_a3, out_v, primed, overrun
  );

  modport slave (
    input  inp_v, packed_in,
    output ready, packed_a0, packed_a1, packed_a2, packed_a3, out_v, primed, overrun
  );
endinterface

// File: rtl/activation_cache.sv
// Dilated activation history: circular flop buffer of 3*DILATION+1 vectors, emitting
// taps x[t], x[t-DIL], x[t-2*DIL], x[t-3*DIL] one cycle after each accepted sample.
module activation_cache #(
  parameter int W        = 16,
  parameter int D        = 8,
  parameter int DILATION = 4
) (
  input logic               clk,
  input logic               rst,
  activation_cache_if.slave bus
);
  localparam int N  = 3 * DILATION + 1;
  localparam int VW = D * W;
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t          state_q, state_d;
  logic            wr_en, emit, drop, ready_c;
  logic [VW-1:0]   mem_q [N];
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            out_v_q;
  logic            overrun_q;

  // (ptr - off) mod N, kept non-negative since off never exceeds N-1
  function automatic logic [PW-1:0] tap_idx(input logic [PW-1:0] ptr, input int off);
    int s;
    s = int'(ptr) + N - off;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    wr_en   = 1'b0;
    emit    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.inp_v) begin
          wr_en   = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        emit    = 1'b1;
        drop    = bus.inp_v;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.packed_in;
    end
  end

  // Counter advances on the emit edge so primed rises together with out_v
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      count_q   <= '0;
      out_v_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      out_v_q <= emit;
      if (emit) begin
        wr_ptr_q <= (wr_ptr_q == PW'(N - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (count_q != CW'(N)) count_q <= count_q + 1'b1;
      end
      if (drop) overrun_q <= 1'b1;
    end
  end

  // Tap gi looks back (3-gi)*DILATION entries from the newest sample
  for (genvar gi = 0; gi < 4; gi++) begin : g_tap
    localparam int OFF = (3 - gi) * DILATION;
    logic [VW-1:0] tap_q;
    always_ff @(posedge clk) begin
      if (rst)       tap_q <= '0;
      else if (emit) tap_q <= mem_q[tap_idx(wr_ptr_q, OFF)];
    end
  end

  assign bus.ready     = ready_c;
  assign bus.packed_a0 = g_tap[0].tap_q;
  assign bus.packed_a1 = g_tap[1].tap_q;
  assign bus.packed_a2 = g_tap[2].tap_q;
  assign bus.packed_a3 = g_tap[3].tap_q;
  assign bus.out_v     = out_v_q;
  assign bus.primed    = (count_q == CW'(N));
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_activation_cache.sv
// Directed bench for activation_cache with DILATION=2 (N=7); sample k has every lane = k.
module tb_activation_cache;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  activation_cache_if #(.W(16), .D(8)) bus ();

  activation_cache #(.W(16), .D(8), .DILATION(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [127:0] samp(input int k);
    logic [15:0] e;
    e = 16'(k);
    return {8{e}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_taps(input string nm, input int e3, input int e2, input int e1, input int e0);
    logic [511:0] got, req;
    got = {bus.packed_a3, bus.packed_a2, bus.packed_a1, bus.packed_a0};
    req = {samp(e3), samp(e2), samp(e1), samp(e0)};
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s taps: a3..a0 lane0 = %h %h %h %h required %h %h %h %h", nm,
               bus.packed_a3[127:112], bus.packed_a2[127:112], bus.packed_a1[127:112],
               bus.packed_a0[127:112], 16'(e3), 16'(e2), 16'(e1), 16'(e0));
    end
  endtask

  // Accept one sample, then verify the EMIT cycle and the out_v cycle
  task automatic send(input int k, input bit chk, input int e3, input int e2, input int e1,
                      input int e0, input bit ep, input string nm);
    bus.inp_v     = 1'b1;
    bus.packed_in = samp(k);
    step();
    bus.inp_v     = 1'b0;
    bus.packed_in = '0;
    total++;
    if (bus.ready !== 1'b0 || bus.out_v !== 1'b0) begin
      bad++;
      $display("FAIL %s emit_cycle: ready=%b out_v=%b required ready=0 out_v=0", nm, bus.ready, bus.out_v);
    end
    step();
    total++;
    if (bus.out_v !== 1'b1) begin
      bad++;
      $display("FAIL %s out_v: got %b required 1", nm, bus.out_v);
    end
    if (chk) begin
      check_taps(nm, e3, e2, e1, e0);
      total++;
      if (bus.primed !== ep) begin
        bad++;
        $display("FAIL %s primed: got %b required %b", nm, bus.primed, ep);
      end
    end
    $display("txn %s sample=%0d out_v=%b a3=%h a2=%h a1=%h a0=%h primed=%b", nm, k, bus.out_v,
             bus.packed_a3[127:112], bus.packed_a2[127:112], bus.packed_a1[127:112],
             bus.packed_a0[127:112], bus.primed);
  endtask

  task automatic check_idle_zero(input string nm);
    total++;
    if (bus.ready !== 1'b1 || bus.out_v !== 1'b0 || bus.primed !== 1'b0 || bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL %s flags: ready=%b out_v=%b primed=%b overrun=%b required 1 0 0 0", nm,
               bus.ready, bus.out_v, bus.primed, bus.overrun);
    end
    check_taps(nm, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.inp_v     = 1'b1;
    bus.packed_in = samp(5);
    step();
    step();
    check_idle_zero("reset");
    bus.inp_v     = 1'b0;
    bus.packed_in = '0;
    rst           = 1'b0;
    step();
    check_idle_zero("reset_release");
    $display("txn reset done");
  endtask

  task automatic test_first_sample();
    send(1, 1'b1, 1, 0, 0, 0, 1'b0, "first");
  endtask

  task automatic test_fill();
    for (int k = 2; k <= 7; k++)
      send(k, 1'b1, k, (k > 2) ? k - 2 : 0, (k > 4) ? k - 4 : 0, (k > 6) ? k - 6 : 0,
           (k == 7), $sformatf("fill%0d", k));
  endtask

  task automatic test_wrap();
    send(8, 1'b1, 8, 6, 4, 2, 1'b1, "wrap8");
    send(9, 1'b1, 9, 7, 5, 3, 1'b1, "wrap9");
    total++;
    if (bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL wrap overrun: got %b required 0", bus.overrun);
    end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (bus.out_v !== 1'b0) begin
        bad++;
        $display("FAIL hold out_v: got %b required 0", bus.out_v);
      end
    end
    check_taps("hold", 9, 7, 5, 3);
    $display("txn hold a3=%h", bus.packed_a3[127:112]);
  endtask

  task automatic test_back_to_back();
    int vals[4] = '{10, 99, 11, 98};
    int pulses = 0;
    logic [127:0] first_a3 = '0;
    for (int c = 0; c < 6; c++) begin
      bus.inp_v     = (c < 4);
      bus.packed_in = (c < 4) ? samp(vals[c]) : '0;
      step();
      if (bus.out_v === 1'b1) begin
        if (pulses == 0) first_a3 = bus.packed_a3;
        pulses++;
      end
    end
    bus.inp_v     = 1'b0;
    bus.packed_in = '0;
    total++;
    if (pulses != 2) begin
      bad++;
      $display("FAIL b2b pulses: got %0d required 2", pulses);
    end
    total++;
    if (first_a3 !== samp(10)) begin
      bad++;
      $display("FAIL b2b first_a3: got %h required %h", first_a3[127:112], 16'd10);
    end
    check_taps("b2b", 11, 9, 7, 5);
    total++;
    if (bus.overrun !== 1'b1 || bus.ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b flags: overrun=%b ready=%b required 1 1", bus.overrun, bus.ready);
    end
    $display("txn b2b pulses=%0d overrun=%b a3=%h", pulses, bus.overrun, bus.packed_a3[127:112]);
  endtask

  task automatic test_reset_mid_emit();
    for (int k = 1; k <= 4; k++)
      send(k, 1'b0, 0, 0, 0, 0, 1'b0, $sformatf("pre%0d", k));
    bus.inp_v     = 1'b1;
    bus.packed_in = samp(5);
    step();
    bus.inp_v     = 1'b0;
    bus.packed_in = '0;
    rst           = 1'b1;
    step();
    check_idle_zero("midrst");
    rst = 1'b0;
    step();
    check_idle_zero("midrst_after");
    $display("txn midrst out_v=%b overrun=%b", bus.out_v, bus.overrun);
    send(1, 1'b1, 1, 0, 0, 0, 1'b0, "post_rst");
  endtask

  initial begin
    rst           = 1'b1;
    bus.inp_v     = 1'b0;
    bus.packed_in = '0;
    #1;
    test_reset();
    test_first_sample();
    test_fill();
    test_wrap();
    test_hold();
    test_back_to_back();
    test_reset_mid_emit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/activation_cache.md
ACTIVATION_CACHE -- requirements
Module: activation_cache

Interface
REQ-001 Parameter W, default 16, SHALL set the bit width of each signed lane element.
REQ-002 Parameter D, default 8, SHALL set the number of lanes per packed vector.
REQ-003 Parameter DILATION, default 4, SHALL set the tap spacing in samples; legal range 1..8.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on the rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 inp_v  input  1  SHALL qualify packed_in; it is a one-cycle request.
REQ-007 packed_in  input  D*W  SHALL carry the current activation vector; lane 0 in the top W bits.
REQ-008 ready  output  1  SHALL be high only when the block can accept inp_v.
REQ-009 packed_a0  output  D*W  SHALL carry sample x[t-3*DILATION].
REQ-010 packed_a1  output  D*W  SHALL carry sample x[t-2*DILATION].
REQ-011 packed_a2  output  D*W  SHALL carry sample x[t-DILATION].
REQ-012 packed_a3  output  D*W  SHALL carry sample x[t], the most recently accepted input.
REQ-013 out_v  output  1  SHALL pulse high for one cycle when packed_a0..a3 are updated.
REQ-014 primed  output  1  SHALL be high once all four taps hold real, non-padding samples.
REQ-015 overrun  output  1  SHALL be a sticky flag set when inp_v is dropped.

Function
REQ-016 The block SHALL hold a circular buffer of N = 3*DILATION+1 entries of D*W bits, implemented in flops.
REQ-017 A write pointer wr_ptr SHALL span 0..N-1 and wrap from N-1 to 0.
REQ-018 The FSM SHALL have exactly two states: IDLE (ready=1) and EMIT (ready=0).
REQ-019 In IDLE with inp_v=1, the block SHALL write packed_in to entry wr_ptr and go to EMIT.
REQ-020 In EMIT, the block SHALL register packed_a3=buf[wr_ptr], packed_a2=buf[(wr_ptr-DILATION) mod N], packed_a1=buf[(wr_ptr-2*DILATION) mod N], packed_a0=buf[(wr_ptr-3*DILATION) mod N].
REQ-021 Also in EMIT, it SHALL assert out_v for that cycle only, advance wr_ptr by 1 with wrap, and return to IDLE.
REQ-022 Latency SHALL be fixed: inp_v sampled at edge k gives out_v=1 and valid taps in the cycle after edge k+1.
REQ-023 Maximum throughput SHALL be one accepted sample every 2 cycles.
REQ-024 inp_v=1 while in EMIT SHALL be dropped: no buffer write, no pointer change, and overrun set to 1 until reset.
REQ-025 Tap outputs SHALL hold their last value between out_v pulses.
REQ-026 Unwritten entries SHALL read as zero (causal zero padding); lane bits SHALL pass through unmodified.
REQ-027 A saturating counter SHALL count accepted samples up to N; primed SHALL be 1 when count equals N.
REQ-028 primed SHALL become 1 in the same cycle as the out_v pulse of the N-th accepted sample.
REQ-029 Taps SHALL remain correct across any number of wr_ptr wrap-arounds.

Reset
REQ-030 While rst=1 at an edge, the block SHALL clear all buffer entries, wr_ptr, the counter, packed_a0..a3, out_v, primed and overrun to 0, and set state to IDLE (ready=1).
REQ-031 rst SHALL take priority over inp_v and over an EMIT in progress; the pending out_v SHALL NOT be issued.

Verification (DILATION=2, N=7; sample k = every lane 16'h000k)
REQ-032 Reset, then accept sample 1 -> two cycles later out_v=1, a3=1, a2=a1=a0=0, primed=0.
REQ-033 Accept samples 1..7 spaced 2 cycles apart -> 7th out_v gives a3=7, a2=5, a1=3, a0=1, primed=1.
REQ-034 Continue with samples 8 and 9 (wrap) -> 9th out_v gives a3=9, a2=7, a1=5, a0=3.
REQ-035 Hold inp_v high for 4 consecutive cycles from IDLE -> 2 samples accepted, 2 dropped, overrun=1, two out_v pulses.
REQ-036 Assert rst in the EMIT cycle after sample 5 -> no out_v pulse; all outputs 0; next sample 1 gives a3=1 and all other taps 0.
